// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point exception stage: flag bit
// positions and the result classification enum.
package fp_pkg;

    localparam int FLG_OVF  = 0;
    localparam int FLG_UNF  = 1;
    localparam int FLG_INV  = 2;
    localparam int FLG_ZERO = 3;
    localparam int FLG_W    = 4;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_OVF    = 2'd1,
        CLS_UNF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational result classifier. NaN wins over overflow, overflow over
// underflow, and anything left over is a normal number.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic [EXP_W+1:0] in_exp,
    input  logic             in_nan,
    output fp_class_t        cls
);

    logic exp_neg;
    logic exp_zero;
    logic exp_ovf;

    // The exponent is two's complement; the top bit is the sign. A
    // non-negative value at or above the all-ones stored exponent overflows.
    assign exp_neg  = in_exp[EXP_W+1];
    assign exp_zero = (in_exp == '0);
    assign exp_ovf  = !exp_neg && (in_exp[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}});

    // Priority encode the class.
    always_comb begin
        cls = CLS_NORMAL;
        if (in_nan) begin
            cls = CLS_NAN;
        end else if (exp_ovf) begin
            cls = CLS_OVF;
        end else if (exp_neg || exp_zero) begin
            cls = CLS_UNF;
        end
    end

endmodule

// File: rtl/fp_exception_stage.sv
// Two-stage exception/packing stage. S1 holds the classified raw result,
// S2 holds the packed IEEE-style word with its per-result flags. Both
// stages use valid/ready handshaking with a combinational ready chain so a
// full pipe still streams one result per cycle.
module fp_exception_stage
    import fp_pkg::*;
#(
    parameter int EXP_W    = 8,
    parameter int FRAC_W   = 23,
    parameter int SAT_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W+1:0]        in_exp,
    input  logic [FRAC_W-1:0]       in_frac,
    input  logic                    in_nan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_word,
    output logic [FLG_W-1:0]        out_flags,
    output logic [FLG_W-1:0]        sticky_flags,
    input  logic                    flag_clr
);

    localparam int WORD_W = 1 + EXP_W + FRAC_W;

    fp_class_t               cls_next;
    fp_class_t               s1_cls_reg;
    logic                    s1_valid_reg;
    logic                    s1_sign_reg;
    logic [EXP_W-1:0]        s1_exp_reg;
    logic [FRAC_W-1:0]       s1_frac_reg;

    logic                    s2_valid_reg;
    logic [WORD_W-1:0]       word_reg;
    logic [FLG_W-1:0]        flags_reg;
    logic [FLG_W-1:0]        sticky_reg;

    logic [WORD_W-1:0]       word_next;
    logic [FLG_W-1:0]        flags_next;
    logic [FLG_W-1:0]        sticky_next;

    logic                    s2_adv;
    logic                    s1_adv;
    logic                    in_xfer;
    logic                    out_xfer;

    fp_classify #(
        .EXP_W (EXP_W)
    ) u_classify (
        .in_exp (in_exp),
        .in_nan (in_nan),
        .cls    (cls_next)
    );

    // A stage may load when it is empty or its content leaves this cycle.
    assign out_xfer = s2_valid_reg && out_ready;
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;
    assign in_xfer  = in_valid && in_ready;

    // S1: capture the class and the raw fields of the accepted result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_cls_reg   <= CLS_NORMAL;
            s1_sign_reg  <= 1'b0;
            s1_exp_reg   <= '0;
            s1_frac_reg  <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_xfer) begin
                s1_cls_reg  <= cls_next;
                s1_sign_reg <= in_sign;
                s1_exp_reg  <= in_exp[EXP_W-1:0];
                s1_frac_reg <= in_frac;
            end
        end
    end

    // Build the packed word and flags for the S1 content.
    always_comb begin
        word_next  = '0;
        flags_next = '0;
        case (s1_cls_reg)
            CLS_NAN: begin
                // Canonical quiet NaN, sign discarded.
                word_next = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
                flags_next[FLG_INV] = 1'b1;
            end
            CLS_OVF: begin
                if (SAT_MODE != 0) begin
                    word_next = {s1_sign_reg, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
                end else begin
                    word_next = {s1_sign_reg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                end
                flags_next[FLG_OVF] = 1'b1;
            end
            CLS_UNF: begin
                // Flush to positive zero.
                word_next = '0;
                flags_next[FLG_UNF]  = 1'b1;
                flags_next[FLG_ZERO] = 1'b1;
            end
            default: begin
                word_next = {s1_sign_reg, s1_exp_reg, s1_frac_reg};
            end
        endcase
    end

    // S2: register the packed result; it holds while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            word_reg     <= '0;
            flags_reg    <= '0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                word_reg  <= word_next;
                flags_reg <= flags_next;
            end
        end
    end

    // Per-bit sticky update: a clear wipes history, then the transfer in the
    // same cycle (if any) is accumulated on top.
    for (genvar gi = 0; gi < FLG_W; gi++) begin : g_sticky
        assign sticky_next[gi] = (flag_clr ? 1'b0 : sticky_reg[gi])
                               | (out_xfer & flags_reg[gi]);
    end

    // Sticky flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_reg <= '0;
        end else begin
            sticky_reg <= sticky_next;
        end
    end

    assign out_valid    = s2_valid_reg;
    assign out_word     = word_reg;
    assign out_flags    = flags_reg;
    assign sticky_flags = sticky_reg;

endmodule

// File: tb/tb_fp_exception_stage.sv
// Scoreboard bench for fp_exception_stage: two instances (wrap-to-infinity
// and saturating overflow) share the same stimulus; expected results are
// queued at acceptance and checked in order as each instance emits them.
module tb_fp_exception_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [22:0] in_frac;
    logic        in_nan;
    logic        out_ready;
    logic        flag_clr;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] out_word0, out_word1;
    logic [3:0]  out_flags0, out_flags1;
    logic [3:0]  sticky0, sticky1;

    int total = 0;
    int bad   = 0;

    logic [35:0] q0[$];
    logic [35:0] q1[$];
    logic [3:0]  sticky_model = 4'b0;
    bit          rand_ready = 0;

    always #5 clk = ~clk;

    fp_exception_stage #(.EXP_W(8), .FRAC_W(23), .SAT_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_nan(in_nan),
        .out_valid(out_valid0), .out_ready(out_ready), .out_word(out_word0),
        .out_flags(out_flags0), .sticky_flags(sticky0), .flag_clr(flag_clr)
    );

    fp_exception_stage #(.EXP_W(8), .FRAC_W(23), .SAT_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_nan(in_nan),
        .out_valid(out_valid1), .out_ready(out_ready), .out_word(out_word1),
        .out_flags(out_flags1), .sticky_flags(sticky1), .flag_clr(flag_clr)
    );

    // Reference behaviour: {word, flags} for one input.
    function automatic logic [35:0] model(bit sat, bit s, int e, logic [22:0] f, bit n);
        logic [7:0] e8;
        e8 = e[7:0];
        if (n)             return {32'h7FC0_0000, 4'b0100};
        else if (e >= 255) return sat ? {s, 8'hFE, 23'h7FFFFF, 4'b0001}
                                      : {s, 8'hFF, 23'h0, 4'b0001};
        else if (e <= 0)   return {32'h0, 4'b1010};
        else               return {s, e8, f, 4'b0000};
    endfunction

    task automatic check(string tag, logic [35:0] obs, logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one input and hold it until accepted (bounded).
    task automatic send(bit s, int e, logic [22:0] f, bit n);
        int guard;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e[9:0];
        in_frac  = f;
        in_nan   = n;
        guard    = 0;
        forever begin
            @(negedge clk);
            if (in_ready0) begin
                q0.push_back(model(0, s, e, f, n));
                q1.push_back(model(1, s, e, f, n));
                $display("send sign=%0d exp=%0d frac=%h nan=%0d", s, e, f, n);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            guard++;
            if (guard > 100) begin
                check("send_timeout", 36'(guard), 36'(0));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 200) begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            guard++;
        end
        check("drain_empty", 36'(q0.size() + q1.size()), 36'(0));
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Output-side scoreboard and stall-stability checks, instance 0.
    logic        stall0 = 1'b0;
    logic [35:0] held0;
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            sticky_model = 4'b0;
            stall0 = 1'b0;
        end else begin
            check("sticky0", {32'h0, sticky0}, {32'h0, sticky_model});
            if (stall0) check("hold0", {out_word0, out_flags0}, held0);
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    check("unexpected0", {out_word0, out_flags0}, 36'h0_0000_0000 ^ ~{out_word0, out_flags0});
                end else begin
                    $display("recv0 word=%h flags=%b", out_word0, out_flags0);
                    check("result0", {out_word0, out_flags0}, q0.pop_front());
                end
            end
            sticky_model = (flag_clr ? 4'b0 : sticky_model) |
                           ((out_valid0 && out_ready) ? out_flags0 : 4'b0);
            stall0 = out_valid0 && !out_ready;
            held0  = {out_word0, out_flags0};
        end
    end

    // Output-side scoreboard, instance 1 (saturating).
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
        end else if (out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                check("unexpected1", {out_word1, out_flags1}, ~{out_word1, out_flags1});
            end else begin
                $display("recv1 word=%h flags=%b", out_word1, out_flags1);
                check("result1", {out_word1, out_flags1}, q1.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 0; in_sign = 0; in_exp = '0; in_frac = '0;
        in_nan = 0; out_ready = 1'b1; flag_clr = 1'b0;
        #2;
        check("rst_out_valid", 36'(out_valid0), 36'(0));
        check("rst_word_flags", {out_word0, out_flags0}, 36'h0);
        check("rst_sticky", 36'(sticky0), 36'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_rst", 36'(in_ready0), 36'(1));

        // Basic normal value with latency observation.
        in_valid = 1; in_sign = 0; in_exp = 10'd127; in_frac = '0; in_nan = 0;
        q0.push_back(model(0, 0, 127, 0, 0));
        q1.push_back(model(1, 0, 127, 0, 0));
        $display("send sign=0 exp=127 frac=0 nan=0");
        @(posedge clk); #1;
        in_valid = 0;
        check("lat_cycle1", 36'(out_valid0), 36'(0));
        @(posedge clk); #1;
        check("lat_cycle2", 36'(out_valid0), 36'(1));
        check("word_1p0", {out_word0, out_flags0}, {32'h3F80_0000, 4'b0000});
        drain();

        // Overflow, underflow and boundary exponents.
        send(1, 300, 23'h0, 0);
        send(1, -3, 23'h5, 0);
        send(1, 0, 23'h5, 0);
        send(0, 254, 23'h7FFFFF, 0);
        send(1, 255, 23'h12345, 0);
        send(0, 1, 23'h1, 0);
        send(0, -512, 23'h1, 0);
        send(0, 511, 23'h1, 0);
        drain();

        // NaN and sticky clear behaviour.
        flag_clr = 1; idle(1); flag_clr = 0; idle(1);
        check("sticky_cleared", 36'(sticky0), 36'(0));
        send(1, 100, 23'h3, 1);
        drain();
        idle(1);
        check("sticky_nan", 36'(sticky0), 36'(4'b0100));
        flag_clr = 1; idle(1); flag_clr = 0;
        check("sticky_clr_alone", 36'(sticky0), 36'(0));

        // Clear coinciding with an output transfer keeps that transfer's flags.
        send(0, 400, 23'h0, 0);
        while (!out_valid0) begin @(posedge clk); #1; end
        flag_clr = 1; idle(1); flag_clr = 0;
        check("clr_with_xfer", 36'(sticky0), 36'(4'b0001));
        drain();

        // Backpressure: two accepted, then in_ready drops.
        out_ready = 0;
        send(0, 10, 23'h11, 0);
        send(1, 20, 23'h22, 0);
        in_valid = 1; in_sign = 0; in_exp = 10'd30; in_frac = 23'h33; in_nan = 0;
        @(negedge clk);
        check("bp_ready_low_a", 36'(in_ready0), 36'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_ready_low_b", 36'(in_ready0), 36'(0));
        @(posedge clk); #1;
        out_ready = 1;
        send(0, 30, 23'h33, 0);
        send(1, 40, 23'h44, 0);
        drain();

        // Random stream under random backpressure.
        rand_ready = 1;
        for (int i = 0; i < 150; i++) begin
            send(1'($urandom_range(0, 1)), $urandom_range(0, 320) - 20,
                 23'($urandom), ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 7) == 0) flag_clr = 1;
            else flag_clr = 0;
        end
        flag_clr = 0;
        drain();
        rand_ready = 0;
        out_ready = 1;

        // Reset with results in flight.
        out_ready = 0;
        send(0, 50, 23'h1, 0);
        send(0, 60, 23'h2, 0);
        rst = 1; #1;
        check("midrst_out_valid", 36'(out_valid0), 36'(0));
        check("midrst_sticky", 36'(sticky0), 36'(0));
        idle(2);
        rst = 0;
        out_ready = 1;
        idle(10);
        check("midrst_no_stale", 36'(q0.size() + q1.size()), 36'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
